muldiv_sequencer: RTL and testbench

Iterative multiply/divide sequencer for the EX stage. It takes over a multi-cycle UMUL/SMUL/UDIV/SDIV (and their cc forms) once the instruction reaches EX, and holds the front of the pipeline via `stall` until the result is ready. It then presents a one-cycle result, Y-register update and ICC update to the EX/MEM boundary, alongside the single-cycle ALU path.

---
 rtl/muldiv_sequencer.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative one-bit-per-cycle multiply/divide unit that stalls EX until its result is ready.
// Optional feature macro: MULDIV_DIV_EN (divide datapath); when undefined, divides complete at once with unimp.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             R,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic             set_cc,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] y_in,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] y_out,
  output logic             y_we,
  output logic             we_psr,
  output logic             Z,
  output logic             N,
  output logic             V,
  output logic             C,
  output logic             div_zero,
  output logic             unimp,
  output logic [2:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_POS  = ~MIN_NEG;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_ITER = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic               cc_q, cc_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               neg_q, neg_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;

  logic               done_q, done_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   y_out_q, y_out_d;
  logic               y_we_q, y_we_d;
  logic               we_psr_q, we_psr_d;
  logic               z_q, z_d;
  logic               n_q, n_d;
  logic               v_q, v_d;
  logic               div_zero_q, div_zero_d;
  logic               unimp_q, unimp_d;

  // Valid/ready contract: start is taken only in IDLE with flush low; stall holds the
  // pipeline from that accept cycle until DONE, where the result is offered for one cycle.
  assign stall = R & (((state_q == S_IDLE) & start & ~flush) |
                      (state_q == S_PREP) | (state_q == S_ITER) | (state_q == S_FIX));
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign result    = result_q;
  assign y_out     = y_out_q;
  assign y_we      = y_we_q;
  assign we_psr    = we_psr_q;
  assign Z         = z_q;
  assign N         = n_q;
  assign V         = v_q;
  assign C         = 1'b0;
  assign div_zero  = div_zero_q;
  assign unimp     = unimp_q;
  assign dbg_state = state_q;

  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     add_sum;
  logic [2*WIDTH-1:0] mul_next, prod;

  // op[0] marks the signed variant for both multiply and divide.
  always_comb begin
    a_neg    = op_q[0] & a_q[WIDTH-1];
    b_neg    = op_q[0] & b_q[WIDTH-1];
    a_mag    = a_neg ? -a_q : a_q;
    b_mag    = b_neg ? -b_q : b_q;
    add_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_next = {add_sum, acc_q[WIDTH-1:1]};
    prod     = neg_q ? -acc_q : acc_q;
  end

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0]   y_q, y_d;
  logic               ovf_q, ovf_d;
  logic               dvd_neg;
  logic [2*WIDTH-1:0] dvd_raw, dvd_mag, div_next;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               q_bit, sdiv_sat, div_v;
  logic [WIDTH-1:0]   q_mag, div_res;

  // Restoring division: acc holds {remainder, dividend low / quotient bits}.
  always_comb begin
    dvd_raw  = {y_q, a_q};
    dvd_neg  = op_q[0] & y_q[WIDTH-1];
    dvd_mag  = dvd_neg ? -dvd_raw : dvd_raw;
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_sub  = rem_sh - {1'b0, b_q};
    q_bit    = ~rem_sub[WIDTH];
    div_next = {(q_bit ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0]), acc_q[WIDTH-2:0], q_bit};
    q_mag    = acc_q[WIDTH-1:0];
    sdiv_sat = ovf_q | (~neg_q & q_mag[WIDTH-1]) | (neg_q & (q_mag > MIN_NEG));
    div_v    = op_q[0] ? sdiv_sat : ovf_q;
    if (!op_q[0])      div_res = ovf_q ? '1 : q_mag;
    else if (sdiv_sat) div_res = neg_q ? MIN_NEG : MAX_POS;
    else               div_res = neg_q ? -q_mag : q_mag;
  end
`else
  logic unused_div;
  assign unused_div = ^{y_in, op_q[1]};
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    cc_d       = cc_q;
    a_d        = a_q;
    b_d        = b_q;
    neg_d      = neg_q;
    acc_d      = acc_q;
`ifdef MULDIV_DIV_EN
    y_d        = y_q;
    ovf_d      = ovf_q;
`endif
    done_d     = 1'b0;
    result_d   = '0;
    y_out_d    = '0;
    y_we_d     = 1'b0;
    we_psr_d   = 1'b0;
    z_d        = 1'b0;
    n_d        = 1'b0;
    v_d        = 1'b0;
    div_zero_d = 1'b0;
    unimp_d    = 1'b0;

    if (flush && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !flush) begin
            op_d = op;
            cc_d = set_cc;
            a_d  = a;
            b_d  = b;
`ifdef MULDIV_DIV_EN
            y_d  = y_in;
            if (op[1] && b == '0) begin
              state_d    = S_DONE;
              done_d     = 1'b1;
              div_zero_d = 1'b1;
            end else begin
              state_d = S_PREP;
            end
`else
            if (op[1]) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              unimp_d = 1'b1;
            end else begin
              state_d = S_PREP;
            end
`endif
          end
        end
        S_PREP: begin
          b_d     = b_mag;
          cnt_d   = CNT_LOAD;
          state_d = S_ITER;
`ifdef MULDIV_DIV_EN
          if (op_q[1]) begin
            acc_d = dvd_mag;
            neg_d = dvd_neg ^ b_neg;
            ovf_d = (dvd_mag[2*WIDTH-1:WIDTH] >= b_mag);
          end else begin
            acc_d = {{WIDTH{1'b0}}, a_mag};
            neg_d = a_neg ^ b_neg;
            ovf_d = 1'b0;
          end
`else
          acc_d = {{WIDTH{1'b0}}, a_mag};
          neg_d = a_neg ^ b_neg;
`endif
        end
        S_ITER: begin
`ifdef MULDIV_DIV_EN
          acc_d = op_q[1] ? div_next : mul_next;
`else
          acc_d = mul_next;
`endif
          if (cnt_q == '0) state_d = S_FIX;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_FIX: begin
          state_d  = S_DONE;
          done_d   = 1'b1;
          we_psr_d = cc_q;
`ifdef MULDIV_DIV_EN
          if (op_q[1]) begin
            result_d = div_res;
            v_d      = div_v;
          end else begin
            result_d = prod[WIDTH-1:0];
            y_out_d  = prod[2*WIDTH-1:WIDTH];
            y_we_d   = 1'b1;
          end
`else
          result_d = prod[WIDTH-1:0];
          y_out_d  = prod[2*WIDTH-1:WIDTH];
          y_we_d   = 1'b1;
`endif
          z_d = (result_d == '0);
          n_d = result_d[WIDTH-1];
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!R) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      op_q       <= '0;
      cc_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      neg_q      <= 1'b0;
      acc_q      <= '0;
`ifdef MULDIV_DIV_EN
      y_q        <= '0;
      ovf_q      <= 1'b0;
`endif
      done_q     <= 1'b0;
      result_q   <= '0;
      y_out_q    <= '0;
      y_we_q     <= 1'b0;
      we_psr_q   <= 1'b0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      v_q        <= 1'b0;
      div_zero_q <= 1'b0;
      unimp_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_q       <= op_d;
      cc_q       <= cc_d;
      a_q        <= a_d;
      b_q        <= b_d;
      neg_q      <= neg_d;
      acc_q      <= acc_d;
`ifdef MULDIV_DIV_EN
      y_q        <= y_d;
      ovf_q      <= ovf_d;
`endif
      done_q     <= done_d;
      result_q   <= result_d;
      y_out_q    <= y_out_d;
      y_we_q     <= y_we_d;
      we_psr_q   <= we_psr_d;
      z_q        <= z_d;
      n_q        <= n_d;
      v_q        <= v_d;
      div_zero_q <= div_zero_d;
      unimp_q    <= unimp_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with hand-computed results for muldiv_sequencer.
// Divide vectors are used when MULDIV_DIV_EN is defined, unimp vectors otherwise.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic clk = 1'b0;
  logic R = 1'b0;
  logic start = 1'b0;
  logic [1:0] op = 2'b00;
  logic set_cc = 1'b0;
  logic flush = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] y_in = '0;

  logic stall, busy, done, y_we, we_psr, Z, N, V, C, div_zero, unimp;
  logic [W-1:0] result, y_out;
  logic [2:0] dbg_state;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .R(R), .start(start), .op(op), .set_cc(set_cc), .flush(flush),
    .a(a), .b(b), .y_in(y_in),
    .stall(stall), .busy(busy), .done(done), .result(result), .y_out(y_out),
    .y_we(y_we), .we_psr(we_psr), .Z(Z), .N(N), .V(V), .C(C),
    .div_zero(div_zero), .unimp(unimp), .dbg_state(dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;
  logic [W-1:0] exp_q[$];

  int got_lat, got_stall_cnt;
  logic got_stall_done, got_ywe, got_wepsr, got_dz, got_unimp;
  logic [W-1:0] got_y;
  logic [3:0] got_flags;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // driver: issue one instruction, follow it to done (bounded), score the result
  task automatic run_op(input string tag, input logic [1:0] op_i, input logic cc_i,
                        input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                        input logic [W-1:0] y_i, input logic [W-1:0] exp_res);
    int cyc;
    bit seen;
    logic [W-1:0] exp_v;
    exp_q.push_back(exp_res);
    @(negedge clk);
    op = op_i; set_cc = cc_i; a = a_i; b = b_i; y_in = y_i; start = 1'b1;
    #1;
    got_stall_cnt = stall ? 1 : 0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    seen = 1'b0;
    got_lat = -1;
    while (!seen && cyc < 60) begin
      if (done) begin
        seen = 1'b1;
        got_lat = cyc;
        got_stall_done = stall;
        got_y = y_out;
        got_ywe = y_we;
        got_wepsr = we_psr;
        got_flags = {Z, N, V, C};
        got_dz = div_zero;
        got_unimp = unimp;
        exp_v = exp_q.pop_front();
        check({tag, "_result"}, 64'(result), 64'(exp_v));
      end else begin
        if (stall) got_stall_cnt++;
        @(negedge clk);
        cyc++;
      end
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 64'(0), 64'(1));
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    int strobes;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_result", 64'(result), 64'(0));
    check("rst_misc", 64'({stall, busy, done, y_we, we_psr, Z, N, V, C, div_zero, unimp}), 64'(0));
    check("rst_state", 64'(dbg_state), 64'(0));
    R = 1'b1;

    // UMUL 0xFFFFFFFF * 2
    run_op("umul", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'hFFFF_FFFE);
    check("umul_lat", 64'(got_lat), 64'(35));
    check("umul_stall_cycles", 64'(got_stall_cnt), 64'(35));
    check("umul_stall_in_done", 64'(got_stall_done), 64'(0));
    check("umul_y", 64'(got_y), 64'(1));
    check("umul_ywe", 64'(got_ywe), 64'(1));
    check("umul_wepsr", 64'(got_wepsr), 64'(0));
    @(negedge clk);
    check("umul_pulse_end", 64'({done, y_we, busy}), 64'(0));

    // SMULcc -3 * 5, then an immediate back-to-back UMUL
    run_op("smulcc", 2'b01, 1'b1, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'hFFFF_FFF1);
    check("smulcc_y", 64'(got_y), 64'hFFFF_FFFF);
    check("smulcc_wepsr", 64'(got_wepsr), 64'(1));
    check("smulcc_flags", 64'(got_flags), 64'(4'b0100));
    run_op("umul_max", 2'b00, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'h0000_0001);
    check("umul_max_lat", 64'(got_lat), 64'(35));
    check("umul_max_y", 64'(got_y), 64'hFFFF_FFFE);

    run_op("smul_min", 2'b01, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'd0, 32'd0);
    check("smul_min_y", 64'(got_y), 64'h4000_0000);
    check("smul_min_flags", 64'(got_flags), 64'(4'b1000));
    run_op("smul_neg", 2'b01, 1'b0, 32'd7, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFF9);
    check("smul_neg_y", 64'(got_y), 64'hFFFF_FFFF);
    run_op("umulcc_zero", 2'b00, 1'b1, 32'd0, 32'h0000_1234, 32'd0, 32'd0);
    check("umulcc_zero_flags", 64'(got_flags), 64'(4'b1000));

`ifdef MULDIV_DIV_EN
    run_op("udiv", 2'b10, 1'b0, 32'd100, 32'd7, 32'd0, 32'd14);
    check("udiv_lat", 64'(got_lat), 64'(35));
    check("udiv_ywe", 64'(got_ywe), 64'(0));
    run_op("udivcc_ovf", 2'b10, 1'b1, 32'd0, 32'd1, 32'd1, 32'hFFFF_FFFF);
    check("udivcc_ovf_flags", 64'(got_flags), 64'(4'b0110));
    check("udivcc_ovf_wepsr", 64'(got_wepsr), 64'(1));
    run_op("sdiv_neg", 2'b11, 1'b0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF2);
    run_op("sdiv_negb", 2'b11, 1'b0, 32'd100, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF2);
    run_op("sdiv_sat_pos", 2'b11, 1'b1, 32'h8000_0000, 32'd1, 32'd0, 32'h7FFF_FFFF);
    check("sdiv_sat_pos_flags", 64'(got_flags), 64'(4'b0010));
    run_op("sdiv_min", 2'b11, 1'b1, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);
    check("sdiv_min_flags", 64'(got_flags), 64'(4'b0100));
    run_op("sdiv_sat_neg", 2'b11, 1'b1, 32'h7FFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);
    check("sdiv_sat_neg_flags", 64'(got_flags), 64'(4'b0110));
    run_op("udiv_zero", 2'b10, 1'b1, 32'd55, 32'd0, 32'd0, 32'd0);
    check("udiv_zero_lat", 64'(got_lat), 64'(1));
    check("udiv_zero_dz", 64'(got_dz), 64'(1));
    check("udiv_zero_strobes", 64'({got_ywe, got_wepsr, got_unimp}), 64'(0));
    @(negedge clk);
    check("udiv_zero_pulse_end", 64'({div_zero, done}), 64'(0));
`else
    run_op("udiv_unimp", 2'b10, 1'b1, 32'd55, 32'd0, 32'd0, 32'd0);
    check("udiv_unimp_lat", 64'(got_lat), 64'(1));
    check("udiv_unimp_flag", 64'(got_unimp), 64'(1));
    check("udiv_unimp_strobes", 64'({got_ywe, got_wepsr, got_dz}), 64'(0));
    run_op("sdiv_unimp", 2'b11, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0);
    check("sdiv_unimp_flag", 64'(got_unimp), 64'(1));
    @(negedge clk);
    check("unimp_pulse_end", 64'({unimp, done}), 64'(0));
`endif

    // flush beats start in IDLE
    @(negedge clk);
    op = 2'b00; a = 32'd3; b = 32'd4; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", 64'(stall), 64'(0));
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", 64'(busy), 64'(0));

    // flush in ITER, then a fresh UMUL 3x4
    @(negedge clk);
    op = 2'b00; set_cc = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("flush_pre_state", 64'(dbg_state), 64'(2));
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", 64'({busy, stall, done}), 64'(0));
    strobes = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || y_we || we_psr || div_zero) strobes++;
    end
    check("flush_no_strobes", 64'(strobes), 64'(0));
    run_op("after_flush", 2'b00, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);
    check("after_flush_y", 64'(got_y), 64'(0));

    // reset in ITER, with start held high while reset is low
    @(negedge clk);
    op = 2'b01; set_cc = 1'b1; a = 32'hFFFF_FFF0; b = 32'h0000_0777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    R = 1'b0;
    @(negedge clk);
    check("rst_mid_result", 64'({result, y_out}), 64'(0));
    check("rst_mid_misc", 64'({stall, busy, done, y_we, we_psr, Z, N, V, C, div_zero, unimp}), 64'(0));
    start = 1'b1;
    #1;
    check("rst_stall_gated", 64'(stall), 64'(0));
    @(negedge clk);
    start = 1'b0;
    R = 1'b1;
    run_op("after_rst", 2'b00, 1'b0, 32'd3, 32'd4, 32'd0, 32'd12);
    check("after_rst_lat", 64'(got_lat), 64'(35));

    // final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
